instr_fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the core: drives word addresses into the synchronous

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 77 +++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path definitions: data widths, PC step, canonical NOP and PC helpers.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [ILEN-1:0] instr_t;

  localparam pc_t    PC_STEP   = 32'd4;
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  // Instructions are word aligned; low target bits from execute are don't-care.
  function automatic pc_t align_pc(pc_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and decode handshake.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  pc_t    imem_addr;
  instr_t imem_rdata;
  logic   redirect_valid;
  pc_t    redirect_pc;
  logic   if_valid;
  logic   if_ready;
  pc_t    if_pc;
  instr_t if_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator over a 1-cycle synchronous memory with replay-based stall
// handling. Optional perf counters enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]                perf_fetch_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  instr_fetch_unit_if.master         bus
);

  pc_t  nxt_pc_q;
  pc_t  rsp_pc_q;
  logic rsp_v_q;
  pc_t  fetch_addr;

  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = bus.redirect_pc[1:0];

  // On a stall the same word is re-read so imem_rdata keeps presenting the held instruction.
  always_comb begin
    if (!rst_n) begin
      fetch_addr = RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_addr = align_pc(bus.redirect_pc);
    end else if (rsp_v_q && !bus.if_ready) begin
      fetch_addr = rsp_pc_q;
    end else begin
      fetch_addr = nxt_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_q  <= 1'b0;
      rsp_pc_q <= RESET_PC;
      nxt_pc_q <= RESET_PC;
    end else begin
      rsp_v_q  <= 1'b1;
      rsp_pc_q <= fetch_addr;
      nxt_pc_q <= fetch_addr + PC_STEP;
    end
  end

  assign bus.imem_addr = fetch_addr;
  assign bus.if_valid  = rsp_v_q & ~bus.redirect_valid;
  assign bus.if_pc     = rsp_pc_q;
  assign bus.if_instr  = bus.imem_rdata;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.if_valid && bus.if_ready) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bus.if_valid && !bus.if_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: program-order stream model, directed scenarios
// with literal expectations, then randomized redirect/back-pressure traffic.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  instr_fetch_unit_if bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  // Synchronous instruction memory, 1-cycle read latency.
  always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

  int checks   = 0;
  int failures = 0;

  // Program-order model: the next instruction decode must see, and whether the stream is live.
  bit          started;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch_cnt;
  logic [31:0] exp_stall_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    started       = 1'b0;
    exp_pc        = RESET_PC;
    exp_fetch_cnt = '0;
    exp_stall_cnt = '0;
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
    chk({tag, "_pc"}, bus.if_pc, RESET_PC);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
`ifdef IFU_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall_cnt, 32'd0);
`endif
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'($urandom_range(0, 1));
    bus.redirect_pc    = $urandom;
    bus.if_ready       = 1'($urandom_range(0, 1));
    #1;
    check_in_reset("reset");
    model_reset();
  endtask

  // One clock: drive inputs, compare outputs against the stream model, advance the model.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    bit          exp_valid;
    @(negedge clk);
    rst_n              = 1'b1;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    #1;
    tgt       = {rpc[31:2], 2'b00};
    exp_valid = started && !rv;
    if (rv)                 exp_addr = tgt;
    else if (started && rdy) exp_addr = exp_pc + 32'd4;
    else                    exp_addr = exp_pc;
    chk("if_valid", {31'd0, bus.if_valid}, {31'd0, exp_valid});
    chk("imem_addr", bus.imem_addr, exp_addr);
    if (exp_valid) begin
      chk("if_pc", bus.if_pc, exp_pc);
      chk("if_instr", bus.if_instr, mem_word(exp_pc));
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, exp_fetch_cnt);
    chk("perf_stall_cnt", perf_stall_cnt, exp_stall_cnt);
`endif
    if (rv) begin
      exp_pc = tgt;
    end else if (started && rdy) begin
      exp_pc        = exp_pc + 32'd4;
      exp_fetch_cnt = exp_fetch_cnt + 32'd1;
    end else if (started) begin
      exp_stall_cnt = exp_stall_cnt + 32'd1;
    end
    started = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 9) < 7));
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;
    model_reset();
    rst_cycle();
    rst_cycle();

    // Sequential stream from reset, first valid one cycle after first posedge.
    cycle(0, 0, 1);
    chk("lit_first_valid_low", {31'd0, bus.if_valid}, 32'd0);
    cycle(0, 0, 1);
    chk("lit_pc0", bus.if_pc, 32'h0);
    chk("lit_instr0", bus.if_instr, 32'hA5A5_0000);
    cycle(0, 0, 1);
    chk("lit_pc4", bus.if_pc, 32'h4);

    // Back-pressure at 0x8 for three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      chk("lit_stall_pc", bus.if_pc, 32'h8);
      chk("lit_stall_instr", bus.if_instr, 32'hA5A5_0008);
      chk("lit_stall_addr", bus.imem_addr, 32'h8);
    end
    cycle(0, 0, 1);
    chk("lit_release_pc8", bus.if_pc, 32'h8);
    cycle(0, 0, 1);
    chk("lit_pcC", bus.if_pc, 32'hC);
    cycle(0, 0, 1);
    chk("lit_pc10", bus.if_pc, 32'h10);

    // Redirect kills the current word.
    cycle(1, 32'h100, 1);
    chk("lit_redir_kill", {31'd0, bus.if_valid}, 32'd0);
    cycle(0, 0, 1);
    chk("lit_pc100", bus.if_pc, 32'h100);
    cycle(0, 0, 1);
    chk("lit_pc104", bus.if_pc, 32'h104);

    // Redirect while stalled, unaligned target, wrap-around.
    cycle(0, 0, 0);
    cycle(1, 32'h200, 0);
    chk("lit_redir_stall_kill", {31'd0, bus.if_valid}, 32'd0);
    chk("lit_redir_stall_addr", bus.imem_addr, 32'h200);
    cycle(1, 32'h302, 1);
    chk("lit_unaligned_addr", bus.imem_addr, 32'h300);
    cycle(0, 0, 1);
    chk("lit_pc300", bus.if_pc, 32'h300);
    cycle(1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 1);
    chk("lit_pcFFFC", bus.if_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 1);
    chk("lit_wrap_pc0", bus.if_pc, 32'h0);

    random_cycles(2000);

    // Async reset while stalled at 0x40.
    cycle(1, 32'h40, 0);
    cycle(0, 0, 0);
    chk("lit_pc40_stalled", bus.if_pc, 32'h40);
    bus.redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset("async_reset");
    model_reset();
    rst_cycle();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("lit_restart_pc", bus.if_pc, RESET_PC);

    random_cycles(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus never waits on the DUT, but guard against a stuck clock loop.
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
